// File: rtl/fma_dot_seq.sv
// Operand sequencer for a pipelined fp32 fma: interleaved dot-product lanes,
// followed by an in-order reduction of the lane sums through the same fma.
module fma_dot_seq #(
    parameter int WORDWIDTH = 32,
    parameter int FMA_LAT   = 3,
    parameter int LEN_W     = 16
) (
    input  logic                 clk_I,
    input  logic                 rst_I,
    input  logic                 start_I,
    input  logic [LEN_W-1:0]     len_I,
    output logic                 busy_O,
    input  logic                 in_valid_I,
    output logic                 in_ready_O,
    input  logic [WORDWIDTH-1:0] in_a_I,
    input  logic [WORDWIDTH-1:0] in_b_I,
    output logic [WORDWIDTH-1:0] fma_a_O,
    output logic [WORDWIDTH-1:0] fma_b_O,
    output logic [WORDWIDTH-1:0] fma_c_O,
    output logic                 fma_gate_O,
    input  logic [WORDWIDTH-1:0] fma_result_I,
    input  logic                 fma_ovf_I,
    input  logic                 fma_unf_I,
    output logic                 out_valid_O,
    input  logic                 out_ready_I,
    output logic [WORDWIDTH-1:0] out_data_O,
    output logic                 out_ovf_O,
    output logic                 out_unf_O
);

    localparam int LW = (FMA_LAT > 1) ? $clog2(FMA_LAT) : 1;
    localparam logic [WORDWIDTH-1:0] ONE = WORDWIDTH'(32'h3F80_0000);
    localparam logic [LW-1:0] LAST = LW'(FMA_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_DRAIN,
        S_RED,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [LEN_W-1:0]     len_q, cnt_q;
    logic [LW-1:0]        slot_q, k_q;
    logic [FMA_LAT-1:0]   tag_vld_q;
    logic [LW-1:0]        tag_lane_q [FMA_LAT];
    logic [WORDWIDTH-1:0] psum_q [FMA_LAT];
    logic [WORDWIDTH-1:0] sum_q;
    logic                 pend_q;
    logic [WORDWIDTH-1:0] a_q, b_q, c_q;
    logic [WORDWIDTH-1:0] a_d, b_d, c_d;
    logic                 busy_q, ovalid_q, ovf_q, unf_q;
    logic [WORDWIDTH-1:0] odata_q;

    logic          ret_vld, acc_issue, red_issue, issue, lane_phase;
    logic [LW-1:0] ret_lane, slot_nxt;

    assign ret_vld    = tag_vld_q[FMA_LAT-1];
    assign ret_lane   = tag_lane_q[FMA_LAT-1];
    assign in_ready_O = (state_q == S_ACC) && (cnt_q != len_q);
    assign acc_issue  = in_ready_O && in_valid_I;
    assign red_issue  = (state_q == S_RED) && !pend_q;
    assign issue      = acc_issue || red_issue;
    assign lane_phase = (state_q == S_ACC) || (state_q == S_DRAIN);
    assign slot_nxt   = (slot_q == LAST) ? '0 : slot_q + 1'b1;

    // Operands go out combinationally on the issue cycle so a lane result
    // returning FMA_LAT cycles later can be bypassed straight into its next issue.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        if (acc_issue) begin
            a_d = in_a_I;
            b_d = in_b_I;
            c_d = (ret_vld && ret_lane == slot_q) ? fma_result_I : psum_q[slot_q];
        end else if (red_issue) begin
            a_d = psum_q[k_q];
            b_d = ONE;
            c_d = sum_q;
        end
    end

    assign fma_a_O     = a_d;
    assign fma_b_O     = b_d;
    assign fma_c_O     = c_d;
    assign fma_gate_O  = !issue;
    assign busy_O      = busy_q;
    assign out_valid_O = ovalid_q;
    assign out_data_O  = odata_q;
    assign out_ovf_O   = ovf_q;
    assign out_unf_O   = unf_q;

    always_ff @(posedge clk_I) begin
        if (rst_I) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            slot_q    <= '0;
            k_q       <= '0;
            tag_vld_q <= '0;
            for (int i = 0; i < FMA_LAT; i++) begin
                tag_lane_q[i] <= '0;
                psum_q[i]     <= '0;
            end
            sum_q    <= '0;
            pend_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            busy_q   <= 1'b0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
            tag_vld_q     <= {tag_vld_q[FMA_LAT-2:0], issue};
            tag_lane_q[0] <= slot_q;
            for (int i = 1; i < FMA_LAT; i++)
                tag_lane_q[i] <= tag_lane_q[i-1];
            if (ret_vld) begin
                ovf_q <= ovf_q | fma_ovf_I;
                unf_q <= unf_q | fma_unf_I;
            end
            if (lane_phase)
                slot_q <= slot_nxt;
            if (lane_phase && ret_vld)
                psum_q[ret_lane] <= fma_result_I;
            if (acc_issue)
                cnt_q <= cnt_q + 1'b1;

            unique case (state_q)
                S_IDLE: begin
                    if (start_I) begin
                        busy_q <= 1'b1;
                        len_q  <= len_I;
                        cnt_q  <= '0;
                        ovf_q  <= 1'b0;
                        unf_q  <= 1'b0;
                        for (int i = 0; i < FMA_LAT; i++)
                            psum_q[i] <= '0;
                        if (len_I == '0) begin
                            state_q  <= S_DONE;
                            ovalid_q <= 1'b1;
                            odata_q  <= '0;
                        end else begin
                            state_q <= S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    if (cnt_q == len_q)
                        state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (tag_vld_q == '0) begin
                        sum_q   <= psum_q[0];
                        k_q     <= LW'(1);
                        pend_q  <= 1'b0;
                        state_q <= S_RED;
                    end
                end
                S_RED: begin
                    if (red_issue) begin
                        pend_q <= 1'b1;
                    end else if (ret_vld) begin
                        sum_q  <= fma_result_I;
                        pend_q <= 1'b0;
                        if (k_q == LAST) begin
                            state_q  <= S_DONE;
                            ovalid_q <= 1'b1;
                            odata_q  <= fma_result_I;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready_I) begin
                        state_q  <= S_IDLE;
                        ovalid_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fma_dot_seq.sv
// Directed bench for fma_dot_seq with a behavioural 3-cycle fp32 fma alongside.
module tb_fma_dot_seq;

    logic        clk = 1'b0;
    logic        rst_I, start_I, in_valid_I, out_ready_I;
    logic [15:0] len_I;
    logic [31:0] in_a_I, in_b_I;
    logic        busy_O, in_ready_O, fma_gate_O, out_valid_O;
    logic [31:0] fma_a_O, fma_b_O, fma_c_O, out_data_O;
    logic [31:0] fma_result_I;
    logic        fma_ovf_I, fma_unf_I, out_ovf_O, out_unf_O;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = !clk;

    fma_dot_seq #(.WORDWIDTH(32), .FMA_LAT(3), .LEN_W(16)) dut (
        .clk_I(clk), .rst_I(rst_I), .start_I(start_I), .len_I(len_I),
        .busy_O(busy_O), .in_valid_I(in_valid_I), .in_ready_O(in_ready_O),
        .in_a_I(in_a_I), .in_b_I(in_b_I),
        .fma_a_O(fma_a_O), .fma_b_O(fma_b_O), .fma_c_O(fma_c_O),
        .fma_gate_O(fma_gate_O), .fma_result_I(fma_result_I),
        .fma_ovf_I(fma_ovf_I), .fma_unf_I(fma_unf_I),
        .out_valid_O(out_valid_O), .out_ready_I(out_ready_I),
        .out_data_O(out_data_O), .out_ovf_O(out_ovf_O), .out_unf_O(out_unf_O)
    );

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        logic [10:0] e;
        if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, 52'h0};
        else if (f[30:23] == 8'h00) d = {f[31], 63'h0};
        else begin
            e = {3'd0, f[30:23]} + 11'd896;
            d = {f[31], e, f[22:0], 29'h0};
        end
        return $bitstoreal(d);
    endfunction

    // {ovf, unf, fp32}; exact for the directed operands used here
    function automatic logic [33:0] fma_ref(input logic [31:0] a, b, c);
        real         r;
        logic [63:0] d;
        int          ex;
        r  = f2r(a) * f2r(b) + f2r(c);
        d  = $realtobits(r);
        ex = int'({21'd0, d[62:52]}) - 896;
        if (d[62:52] == 11'h000) return {2'b00, d[63], 31'h0};
        if (d[62:52] == 11'h7FF || ex >= 255) return {2'b10, d[63], 8'hFF, 23'h0};
        if (ex <= 0) return {2'b01, d[63], 31'h0};
        return {2'b00, d[63], ex[7:0], d[51:29]};
    endfunction

    logic [33:0] pipe [3];
    initial for (int i = 0; i < 3; i++) pipe[i] = '0;
    always @(posedge clk) begin
        pipe[0] <= fma_ref(fma_a_O, fma_b_O, fma_c_O);
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end
    assign fma_result_I = pipe[2][31:0];
    assign fma_ovf_I    = pipe[2][33];
    assign fma_unf_I    = pipe[2][32];

    task automatic chk(input string tag, input logic [31:0] obs, exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a job and feeds it until out_valid_O rises (bounded).
    task automatic job(input int len, input logic [31:0] a, b, input bit gaps,
                       output int issues, output int cycles);
        int  sent;
        bit  ph;
        issues  = 0;
        cycles  = 0;
        sent    = 0;
        ph      = 1'b1;
        start_I = 1'b1;
        len_I   = len[15:0];
        in_a_I  = a;
        in_b_I  = b;
        @(negedge clk);
        if (!fma_gate_O) issues++;
        tick();
        start_I = 1'b0;
        while (!out_valid_O && cycles < 200) begin
            in_valid_I = (sent < len) && (!gaps || ph);
            ph = !ph;
            @(negedge clk);
            if (!fma_gate_O) issues++;
            if (in_valid_I && in_ready_O) sent++;
            tick();
            cycles++;
        end
        in_valid_I = 1'b0;
    endtask

    task automatic handshake(input string tag);
        out_ready_I = 1'b1;
        tick();
        out_ready_I = 1'b0;
        chk({tag, "_busy_drop"}, 32'(busy_O), 32'd0);
        chk({tag, "_valid_drop"}, 32'(out_valid_O), 32'd0);
    endtask

    initial begin
        int          iss, cyc, bad, sent;
        logic [31:0] d0;
        rst_I       = 1'b1;
        start_I     = 1'b0;
        len_I       = '0;
        in_valid_I  = 1'b0;
        in_a_I      = '0;
        in_b_I      = '0;
        out_ready_I = 1'b0;
        tick();
        tick();
        rst_I = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy_O), 32'd0);
        chk("rst_ready", 32'(in_ready_O), 32'd0);
        chk("rst_valid", 32'(out_valid_O), 32'd0);
        chk("rst_gate", 32'(fma_gate_O), 32'd1);
        chk("rst_data", out_data_O, 32'h0);
        tick();

        // 4 x (1.0 * 2.0) back to back
        job(4, 32'h3F80_0000, 32'h4000_0000, 1'b0, iss, cyc);
        chk("t1_timeout", 32'(out_valid_O), 32'd1);
        chk("t1_data", out_data_O, 32'h4100_0000);
        chk("t1_ovf", 32'(out_ovf_O), 32'd0);
        chk("t1_unf", 32'(out_unf_O), 32'd0);
        chk("t1_issues", 32'(iss), 32'd6);
        chk("t1_busy", 32'(busy_O), 32'd1);
        handshake("t1");

        // 3 x (1.5 * 2.0) with in_valid toggling
        job(3, 32'h3FC0_0000, 32'h4000_0000, 1'b1, iss, cyc);
        chk("t2_timeout", 32'(out_valid_O), 32'd1);
        chk("t2_data", out_data_O, 32'h4110_0000);
        chk("t2_issues", 32'(iss), 32'd5);
        handshake("t2");

        // zero-length job
        job(0, 32'h3F80_0000, 32'h3F80_0000, 1'b0, iss, cyc);
        chk("t3_latency", 32'(cyc), 32'd0);
        chk("t3_valid", 32'(out_valid_O), 32'd1);
        chk("t3_data", out_data_O, 32'h0);
        chk("t3_issues", 32'(iss), 32'd0);
        handshake("t3");

        // overflow to +inf, then hold in DONE with start pulses
        job(2, 32'h7F7F_FFFF, 32'h4000_0000, 1'b0, iss, cyc);
        chk("t4_timeout", 32'(out_valid_O), 32'd1);
        chk("t4_data", out_data_O, 32'h7F80_0000);
        chk("t4_ovf", 32'(out_ovf_O), 32'd1);
        chk("t4_unf", 32'(out_unf_O), 32'd0);
        d0  = out_data_O;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            start_I = i[0];
            len_I   = 16'd0;
            tick();
            if (out_valid_O !== 1'b1 || out_data_O !== d0 ||
                out_ovf_O !== 1'b1 || busy_O !== 1'b1) bad++;
        end
        start_I = 1'b0;
        chk("t5_hold", 32'(bad), 32'd0);
        chk("t5_data", out_data_O, 32'h7F80_0000);
        handshake("t5");

        // reset after 2 of 5 pairs, then a fresh 1-term job
        start_I = 1'b1;
        len_I   = 16'd5;
        in_a_I  = 32'h4000_0000;
        in_b_I  = 32'h4000_0000;
        tick();
        start_I    = 1'b0;
        sent       = 0;
        in_valid_I = 1'b1;
        for (int i = 0; i < 20 && sent < 2; i++) begin
            @(negedge clk);
            if (in_ready_O) sent++;
            tick();
        end
        in_valid_I = 1'b0;
        chk("t6_sent", 32'(sent), 32'd2);
        rst_I = 1'b1;
        tick();
        rst_I = 1'b0;
        chk("t6_rst_busy", 32'(busy_O), 32'd0);
        chk("t6_rst_ready", 32'(in_ready_O), 32'd0);
        chk("t6_rst_valid", 32'(out_valid_O), 32'd0);
        job(1, 32'h3F80_0000, 32'h3F80_0000, 1'b0, iss, cyc);
        chk("t6_timeout", 32'(out_valid_O), 32'd1);
        chk("t6_data", out_data_O, 32'h3F80_0000);
        chk("t6_ovf", 32'(out_ovf_O), 32'd0);
        chk("t6_issues", 32'(iss), 32'd3);
        handshake("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
